// File: rtl/seq_signed_rem_div.sv
// rtl/seq_signed_rem_div.sv - multi-cycle sign-magnitude divider with quotient, remainder and divide-by-zero flag
//
// Purpose: restoring division of sign-magnitude operands, one quotient bit per
// clock, MSB first. One division in flight at a time.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   start       request; accepted only in IDLE or DONE
//   numerator   sign-magnitude dividend, sampled on accepted start
//   denominator sign-magnitude divisor, sampled on accepted start
//   busy        high while iterating
//   done        level, high while results are valid
//   quotient    sign-magnitude quotient
//   remainder   sign-magnitude remainder (takes the dividend's sign)
//   divbyzero   divisor magnitude was zero on the last completed division
module seq_signed_rem_div #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divbyzero
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(M);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           num_sign_q, num_sign_d;
  logic           den_sign_q, den_sign_d;
  logic [M-1:0]   den_mag_q, den_mag_d;
  logic [M-1:0]   dvd_q, dvd_d;      // dividend magnitude, shifted out MSB first
  logic [M-1:0]   acc_q, acc_d;      // partial remainder, always < den_mag_q
  logic [M-1:0]   quo_q, quo_d;      // quotient bits collected so far
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic           divbyzero_q, divbyzero_d;

  // One restoring step. The shifted value needs M+1 bits; since acc < den,
  // a set top bit guarantees the trial subtraction succeeds and fits in M bits.
  logic [M:0]   shifted;
  logic [M:0]   trial;
  logic         step_bit;
  logic [M-1:0] acc_step;
  logic [M-1:0] quo_step;

  always_comb begin
    shifted  = {acc_q, dvd_q[M-1]};
    trial    = shifted - {1'b0, den_mag_q};
    step_bit = ~trial[M];
    acc_step = step_bit ? trial[M-1:0] : shifted[M-1:0];
    quo_step = {quo_q[M-2:0], step_bit};
  end

  always_comb begin
    state_d     = state_q;
    num_sign_d  = num_sign_q;
    den_sign_d  = den_sign_q;
    den_mag_d   = den_mag_q;
    dvd_d       = dvd_q;
    acc_d       = acc_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divbyzero_d = divbyzero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_sign_d = numerator[M];
          den_sign_d = denominator[M];
          den_mag_d  = denominator[M-1:0];
          dvd_d      = numerator[M-1:0];
          acc_d      = '0;
          quo_d      = '0;
          cnt_d      = CNT_INIT;
          done_d     = 1'b0;
          if (denominator[M-1:0] == '0) begin
            // +0 and -0 divisors finish immediately; dividend passes through as-is
            state_d     = S_DONE;
            done_d      = 1'b1;
            divbyzero_d = 1'b1;
            quotient_d  = '0;
            remainder_d = numerator;
          end else begin
            state_d = S_BUSY;
            busy_d  = 1'b1;
          end
        end
      end
      S_BUSY: begin
        acc_d = acc_step;
        quo_d = quo_step;
        dvd_d = {dvd_q[M-2:0], 1'b0};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          divbyzero_d = 1'b0;
          // zero magnitudes never carry a sign bit
          quotient_d  = {(|quo_step) & (num_sign_q ^ den_sign_q), quo_step};
          remainder_d = {(|acc_step) & num_sign_q, acc_step};
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_sign_q  <= 1'b0;
      den_sign_q  <= 1'b0;
      den_mag_q   <= '0;
      dvd_q       <= '0;
      acc_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divbyzero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_sign_q  <= num_sign_d;
      den_sign_q  <= den_sign_d;
      den_mag_q   <= den_mag_d;
      dvd_q       <= dvd_d;
      acc_q       <= acc_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divbyzero_q <= divbyzero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign divbyzero = divbyzero_q;

endmodule

// File: tb/tb_seq_signed_rem_div.sv
// tb/tb_seq_signed_rem_div.sv - self-checking bench for seq_signed_rem_div at WIDTH 3 and 8
module tb_seq_signed_rem_div;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       s3 = 1'b0, busy3, done3, dz3;
  logic [2:0] n3 = '0, d3 = '0, q3, r3;
  logic       s8 = 1'b0, busy8, done8, dz8;
  logic [7:0] n8 = '0, d8 = '0, q8, r8;

  seq_signed_rem_div #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(s3), .numerator(n3), .denominator(d3),
    .busy(busy3), .done(done3), .quotient(q3), .remainder(r3), .divbyzero(dz3));

  seq_signed_rem_div #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .numerator(n8), .denominator(d8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .divbyzero(dz8));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sign-magnitude truncating division from the arithmetic definition.
  task automatic model(input int w, input int num, input int den,
                       output int q, output int r, output int dz);
    int m, nm, dm, ns, ds, qm, rm;
    m  = w - 1;
    nm = num % (1 << m);
    dm = den % (1 << m);
    ns = (num >> m) & 1;
    ds = (den >> m) & 1;
    if (dm == 0) begin
      dz = 1; q = 0; r = num;
    end else begin
      dz = 0;
      qm = nm / dm;
      rm = nm % dm;
      q  = ((qm != 0) ? (ns ^ ds) : 0) * (1 << m) + qm;
      r  = ((rm != 0) ? ns : 0) * (1 << m) + rm;
    end
  endtask

  // Issue one start, then count edges after the start edge until done.
  // edges = 0 means done was already high right after the start edge.
  task automatic do_div(input int w, input int num, input int den,
                        output int q, output int r, output int dz,
                        output int edges, output int busy_e0);
    logic dn;
    @(negedge clk);
    if (w == 3) begin n3 = 3'(num); d3 = 3'(den); s3 = 1'b1; end
    else        begin n8 = 8'(num); d8 = 8'(den); s8 = 1'b1; end
    @(posedge clk); #1;
    s3 = 1'b0; s8 = 1'b0;
    busy_e0 = (w == 3) ? int'(busy3) : int'(busy8);
    edges = 0;
    dn = (w == 3) ? done3 : done8;
    while (!dn && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      dn = (w == 3) ? done3 : done8;
    end
    if (!dn) check("done_timeout", 0, 1);
    if (w == 3) begin q = int'(q3); r = int'(r3); dz = int'(dz3); end
    else        begin q = int'(q8); r = int'(r8); dz = int'(dz8); end
  endtask

  typedef struct {
    int num; int den; int q; int r; int dz;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int q, r, dz, edges, be0, eq, er, edz;

    vecs[0] = '{3'b011, 3'b010, 3'b001, 3'b001, 0};
    vecs[1] = '{3'b111, 3'b010, 3'b101, 3'b101, 0};
    vecs[2] = '{3'b110, 3'b001, 3'b110, 3'b000, 0};
    vecs[3] = '{3'b111, 3'b100, 3'b000, 3'b111, 1};
    vecs[4] = '{3'b111, 3'b000, 3'b000, 3'b111, 1};
    vecs[5] = '{3'b101, 3'b011, 3'b000, 3'b101, 0};
    vecs[6] = '{3'b011, 3'b111, 3'b101, 3'b000, 0};
    vecs[7] = '{3'b001, 3'b011, 3'b000, 3'b001, 0};

    #12;
    check("rst_busy3", int'(busy3), 0);
    check("rst_done3", int'(done3), 0);
    check("rst_q8", int'(q8), 0);
    check("rst_r8", int'(r8), 0);
    check("rst_dz8", int'(dz8), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed WIDTH=3 table
    foreach (vecs[i]) begin
      do_div(3, vecs[i].num, vecs[i].den, q, r, dz, edges, be0);
      check($sformatf("tbl%0d_q", i), q, vecs[i].q);
      check($sformatf("tbl%0d_r", i), r, vecs[i].r);
      check($sformatf("tbl%0d_dz", i), dz, vecs[i].dz);
      check($sformatf("tbl%0d_lat", i), edges, vecs[i].dz ? 0 : 2);
      check($sformatf("tbl%0d_busy", i), be0, vecs[i].dz ? 0 : 1);
    end

    // Exhaustive WIDTH=3, back-to-back from DONE
    for (int n = 0; n < 8; n++) begin
      for (int d = 0; d < 8; d++) begin
        do_div(3, n, d, q, r, dz, edges, be0);
        model(3, n, d, eq, er, edz);
        check($sformatf("ex%0d_%0d_q", n, d), q, eq);
        check($sformatf("ex%0d_%0d_r", n, d), r, er);
        check($sformatf("ex%0d_%0d_dz", n, d), dz, edz);
        check($sformatf("ex%0d_%0d_lat", n, d), edges, (d % 4 == 0) ? 0 : 2);
      end
    end

    // WIDTH=8 127/10
    do_div(8, 8'h7F, 8'h0A, q, r, dz, edges, be0);
    check("w8_q", q, 8'h0C);
    check("w8_r", r, 8'h07);
    check("w8_lat", edges, 7);

    // WIDTH=8 start pulsed mid-BUSY is ignored; old outputs held on new start
    @(negedge clk);
    n8 = 8'h7F; d8 = 8'h0A; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    check("hold_q_after_start", int'(q8), 8'h0C);
    check("hold_done_drop", int'(done8), 0);
    repeat (2) @(posedge clk);
    #1;
    n8 = 8'h85; d8 = 8'h03; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0; n8 = '0; d8 = '0;
    edges = 3;
    while (!done8 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("ign_lat", edges, 7);
    check("ign_q", int'(q8), 8'h0C);
    check("ign_r", int'(r8), 8'h07);
    check("ign_dz", int'(dz8), 0);

    // done is a level
    repeat (3) @(posedge clk);
    #1;
    check("done_level", int'(done8), 1);

    // Randomised WIDTH=8 against the reference model
    for (int k = 0; k < 150; k++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = (k % 25 == 0) ? int'($urandom_range(0, 1)) * 128 : int'($urandom_range(0, 255));
      do_div(8, a, b, q, r, dz, edges, be0);
      model(8, a, b, eq, er, edz);
      check($sformatf("rnd%0d_q", k), q, eq);
      check($sformatf("rnd%0d_r", k), r, er);
      check($sformatf("rnd%0d_dz", k), dz, edz);
      check($sformatf("rnd%0d_lat", k), edges, edz ? 0 : 7);
    end

    // Async reset between edges mid-BUSY
    @(negedge clk);
    n8 = 8'hFF; d8 = 8'h05; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", int'(busy8), 0);
    check("arst_done", int'(done8), 0);
    check("arst_q", int'(q8), 0);
    check("arst_r", int'(r8), 0);
    check("arst_dz", int'(dz8), 0);
    @(negedge clk);
    rst = 1'b0;
    do_div(8, 8'hFF, 8'h05, q, r, dz, edges, be0);
    check("post_rst_q", q, 8'h99);
    check("post_rst_r", r, 8'h82);
    check("post_rst_lat", edges, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
